// File: rtl/axi_burst_write_master.sv
// AXI4 write-burst master: one command becomes one AW/W/B burst
// with generated data and byte-accurate strobes.
module axi_burst_write_master #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 8,
  parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8
) (
  input  logic                      axi_clk,
  input  logic                      axi_reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]                cmd_len,
  input  logic [2:0]                cmd_size,
  input  logic [1:0]                cmd_burst,
  input  logic [AXI_ID_WIDTH-1:0]   cmd_id,
  input  logic [AXI_DATA_WIDTH-1:0] cmd_seed,
  output logic [AXI_ADDR_WIDTH-1:0] axi_aw_addr,
  output logic [1:0]                axi_aw_burst,
  output logic [2:0]                axi_aw_size,
  output logic [AXI_ID_WIDTH-1:0]   axi_aw_id,
  output logic [7:0]                axi_aw_len,
  output logic                      axi_aw_valid,
  input  logic                      axi_aw_ready,
  output logic [AXI_DATA_WIDTH-1:0] axi_w_data,
  output logic [AXI_STRB_WIDTH-1:0] axi_w_strb,
  output logic                      axi_w_last,
  output logic                      axi_w_valid,
  input  logic                      axi_w_ready,
  input  logic [1:0]                axi_b_resp,
  input  logic [AXI_ID_WIDTH-1:0]   axi_b_id,
  input  logic                      axi_b_valid,
  output logic                      axi_b_ready,
  output logic                      done_valid,
  output logic [1:0]                done_resp,
  output logic                      done_id_err,
  output logic                      done_cmd_err
);
  localparam int AW = AXI_ADDR_WIDTH;
  localparam int SW = $clog2(AXI_STRB_WIDTH);

  typedef enum logic [2:0] {IDLE, AWS, WS, RESP, DONE, ERR} state_t;
  state_t state, state_nxt;

  logic [AW-1:0] addr_q, beat_q, wmask_q;
  logic [7:0] len_q, cnt_q;
  logic [2:0] size_q;
  logic [1:0] burst_q, resp_q;
  logic [AXI_ID_WIDTH-1:0] id_q;
  logic [AXI_DATA_WIDTH-1:0] data_q;
  logic id_err_q;

  logic accept, w_hs, b_hs, last, legal;
  logic [31:0] span, end_off;
  logic [11:0] page_off;
  logic [AW-1:0] cmd_bmask, bmask, beat_nxt, lo_a, hi_a, lane_mask;
  logic [AXI_STRB_WIDTH-1:0] strb_c;

  assign accept = cmd_valid && cmd_ready;
  assign w_hs   = axi_w_valid && axi_w_ready;
  assign b_hs   = axi_b_valid && axi_b_ready;
  assign last   = cnt_q == len_q;

  // An INCR burst may not cross a 4 KB page.
  always_comb begin
    cmd_bmask = (AW'(1) << cmd_size) - AW'(1);
    page_off  = cmd_addr[11:0] & ~cmd_bmask[11:0];
    span      = (32'(cmd_len) + 32'd1) << cmd_size;
    end_off   = 32'(page_off) + span - 32'd1;
    legal     = 1'b1;
    if (32'(cmd_size) > 32'(SW)) legal = 1'b0;
    if (cmd_burst == 2'd3) legal = 1'b0;
    if (cmd_burst == 2'd2 &&
        !(cmd_len inside {8'd1, 8'd3, 8'd7, 8'd15}))
      legal = 1'b0;
    if (cmd_burst == 2'd2 && (cmd_addr & cmd_bmask) != '0)
      legal = 1'b0;
    if (cmd_burst == 2'd1 && end_off[31:12] != '0)
      legal = 1'b0;
  end

  always_ff @(posedge axi_clk) begin
    if (axi_reset) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = legal ? AWS : ERR;
      AWS:  if (axi_aw_ready) state_nxt = WS;
      WS:   if (axi_w_ready && last) state_nxt = RESP;
      RESP: if (axi_b_valid) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      ERR:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready    = 1'b0;
    axi_aw_valid = 1'b0;
    axi_w_valid  = 1'b0;
    axi_b_ready  = 1'b0;
    done_valid   = 1'b0;
    done_cmd_err = 1'b0;
    case (state)
      IDLE: cmd_ready = !axi_reset;
      AWS:  axi_aw_valid = 1'b1;
      WS:   axi_w_valid = 1'b1;
      RESP: axi_b_ready = 1'b1;
      DONE: done_valid = 1'b1;
      ERR: begin
        done_valid   = 1'b1;
        done_cmd_err = 1'b1;
      end
      default: ;
    endcase
  end

  // Next beat address and the byte lanes of the current beat.
  always_comb begin
    bmask    = (AW'(1) << size_q) - AW'(1);
    beat_nxt = beat_q;
    case (burst_q)
      2'd1: beat_nxt = (beat_q & ~bmask) + bmask + AW'(1);
      2'd2: beat_nxt = (beat_q & ~wmask_q) |
                       ((beat_q + bmask + AW'(1)) & wmask_q);
      default: beat_nxt = beat_q;
    endcase
    lane_mask = AW'(AXI_STRB_WIDTH - 1);
    lo_a = beat_q & lane_mask;
    hi_a = (beat_q & ~bmask & lane_mask) + bmask;
    for (int j = 0; j < AXI_STRB_WIDTH; j++)
      strb_c[j] = (AW'(j) >= lo_a) && (AW'(j) <= hi_a);
  end

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      addr_q   <= '0;
      beat_q   <= '0;
      wmask_q  <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      id_q     <= '0;
      data_q   <= '0;
      resp_q   <= '0;
      id_err_q <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= cmd_addr;
        beat_q  <= cmd_addr;
        wmask_q <= AW'(span) - AW'(1);
        len_q   <= cmd_len;
        cnt_q   <= '0;
        size_q  <= cmd_size;
        burst_q <= cmd_burst;
        id_q    <= cmd_id;
        data_q  <= cmd_seed;
      end
      if (w_hs) begin
        beat_q <= beat_nxt;
        data_q <= data_q + AXI_DATA_WIDTH'(1);
        cnt_q  <= cnt_q + 8'd1;
      end
      if (b_hs) begin
        resp_q   <= axi_b_resp;
        id_err_q <= axi_b_id != id_q;
      end
    end
  end

  assign axi_aw_addr  = addr_q;
  assign axi_aw_burst = burst_q;
  assign axi_aw_size  = size_q;
  assign axi_aw_id    = id_q;
  assign axi_aw_len   = len_q;
  assign axi_w_data   = data_q;
  assign axi_w_strb   = (state == WS) ? strb_c : '0;
  assign axi_w_last   = (state == WS) && last;
  assign done_resp    = (state == DONE) ? resp_q : 2'b00;
  assign done_id_err  = (state == DONE) && id_err_q;
endmodule

// File: tb/tb_axi_burst_write_master.sv
// Directed bench for axi_burst_write_master: bursts, strobes,
// stalls, illegal commands and mid-burst reset.
module tb_axi_burst_write_master;
  logic axi_clk = 1'b0;
  logic axi_reset = 1'b1;
  always #5 axi_clk = ~axi_clk;

  logic cmd_valid, cmd_ready;
  logic [31:0] cmd_addr, cmd_seed;
  logic [7:0] cmd_len, cmd_id;
  logic [2:0] cmd_size;
  logic [1:0] cmd_burst;
  logic [31:0] axi_aw_addr;
  logic [1:0] axi_aw_burst;
  logic [2:0] axi_aw_size;
  logic [7:0] axi_aw_id, axi_aw_len;
  logic axi_aw_valid, axi_aw_ready;
  logic [31:0] axi_w_data;
  logic [3:0] axi_w_strb;
  logic axi_w_last, axi_w_valid, axi_w_ready;
  logic [1:0] axi_b_resp;
  logic [7:0] axi_b_id;
  logic axi_b_valid, axi_b_ready;
  logic done_valid, done_id_err, done_cmd_err;
  logic [1:0] done_resp;

  axi_burst_write_master dut (
    .axi_clk(axi_clk), .axi_reset(axi_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .cmd_id(cmd_id), .cmd_seed(cmd_seed),
    .axi_aw_addr(axi_aw_addr), .axi_aw_burst(axi_aw_burst),
    .axi_aw_size(axi_aw_size), .axi_aw_id(axi_aw_id),
    .axi_aw_len(axi_aw_len), .axi_aw_valid(axi_aw_valid),
    .axi_aw_ready(axi_aw_ready),
    .axi_w_data(axi_w_data), .axi_w_strb(axi_w_strb),
    .axi_w_last(axi_w_last), .axi_w_valid(axi_w_valid),
    .axi_w_ready(axi_w_ready),
    .axi_b_resp(axi_b_resp), .axi_b_id(axi_b_id),
    .axi_b_valid(axi_b_valid), .axi_b_ready(axi_b_ready),
    .done_valid(done_valid), .done_resp(done_resp),
    .done_id_err(done_id_err), .done_cmd_err(done_cmd_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  int aw_stall_n = 0;
  logic [3:0] w_pat = 4'hF;

  int r_aw_first, r_w_first, r_done_cyc, nbeats;
  logic r_aw_seen, r_w_seen, r_cmd_err, r_id_err;
  logic [1:0] r_resp;
  logic [52:0] r_aw;
  logic [31:0] bdata [32];
  logic [3:0] bstrb [32];
  logic blast [32];

  task automatic run_cmd(input logic [31:0] a, input logic [7:0] l,
                         input logic [2:0] s, input logic [1:0] b,
                         input logic [7:0] id, input logic [31:0] seed);
    int aw_st, w_cyc;
    logic aw_done, aw_hold, w_hold;
    logic [52:0] p_aw;
    logic [36:0] p_w;
    aw_st = 0; w_cyc = 0; nbeats = 0;
    aw_done = 0; aw_hold = 0; w_hold = 0;
    p_aw = '0; p_w = '0;
    r_aw_first = -1; r_w_first = -1; r_done_cyc = -1;
    r_aw_seen = 0; r_w_seen = 0; r_aw = '0;
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1; cmd_addr = a; cmd_len = l; cmd_size = s;
    cmd_burst = b; cmd_id = id; cmd_seed = seed;
    @(negedge axi_clk);
    cmd_valid = 0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      axi_aw_ready = 1; axi_w_ready = 1;
      if (axi_w_valid) begin
        if (!r_w_seen) begin
          r_w_first = cyc;
          check("w_after_aw", aw_done, 1);
        end
        if (w_hold)
          check("w_stable", {axi_w_data, axi_w_strb, axi_w_last}, p_w);
        r_w_seen = 1;
        axi_w_ready = w_pat[w_cyc % 4];
        w_cyc++;
        w_hold = !axi_w_ready;
        p_w = {axi_w_data, axi_w_strb, axi_w_last};
        if (axi_w_ready && nbeats < 32) begin
          bdata[nbeats] = axi_w_data;
          bstrb[nbeats] = axi_w_strb;
          blast[nbeats] = axi_w_last;
          nbeats++;
        end
      end
      if (axi_aw_valid) begin
        if (!r_aw_seen) begin
          r_aw_first = cyc;
          r_aw = {axi_aw_addr, axi_aw_len, axi_aw_size,
                  axi_aw_burst, axi_aw_id};
        end
        if (aw_hold)
          check("aw_stable", {axi_aw_addr, axi_aw_len, axi_aw_size,
                              axi_aw_burst, axi_aw_id}, p_aw);
        r_aw_seen = 1;
        axi_aw_ready = aw_st >= aw_stall_n;
        aw_st++;
        aw_hold = !axi_aw_ready;
        p_aw = {axi_aw_addr, axi_aw_len, axi_aw_size,
                axi_aw_burst, axi_aw_id};
        if (axi_aw_ready) aw_done = 1;
      end
      if (done_valid) begin
        r_done_cyc = cyc;
        r_resp = done_resp;
        r_id_err = done_id_err;
        r_cmd_err = done_cmd_err;
        break;
      end
      @(negedge axi_clk);
    end
    if (r_done_cyc < 0) check("done_timeout", 0, 1);
    @(negedge axi_clk);
    check("done_one_cycle", done_valid, 0);
    check("cmd_ready_after_done", cmd_ready, 1);
  endtask

  task automatic check_run(input int n, input logic [31:0] seed,
                           input logic [63:0] es, input int dcyc,
                           input logic [1:0] resp, input logic iderr);
    logic [31:0] ed;
    check("beat_count", nbeats, n);
    for (int i = 0; i < n; i++) begin
      ed = seed + 32'(i);
      check("w_data", bdata[i], ed);
      check("w_strb", bstrb[i], es[i*4 +: 4]);
      check("w_last", blast[i], i == n - 1);
    end
    if (dcyc > 0) check("done_latency", r_done_cyc, dcyc);
    check("done_resp", r_resp, resp);
    check("done_id_err", r_id_err, iderr);
    check("done_cmd_err", r_cmd_err, 0);
  endtask

  task automatic run_illegal(input logic [31:0] a, input logic [7:0] l,
                             input logic [2:0] s, input logic [1:0] b);
    run_cmd(a, l, s, b, 8'h33, 32'h0);
    check("ill_done_cyc", r_done_cyc, 1);
    check("ill_cmd_err", r_cmd_err, 1);
    check("ill_resp", r_resp, 0);
    check("ill_aw_seen", r_aw_seen, 0);
    check("ill_w_seen", r_w_seen, 0);
  endtask

  initial begin
    int rst_seen;
    cmd_valid = 0; cmd_addr = 0; cmd_len = 0; cmd_size = 0;
    cmd_burst = 0; cmd_id = 0; cmd_seed = 0;
    axi_aw_ready = 1; axi_w_ready = 1;
    axi_b_valid = 1; axi_b_resp = 2'b00; axi_b_id = 8'h00;

    repeat (2) @(negedge axi_clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_valids", {axi_aw_valid, axi_w_valid, done_valid}, 0);
    check("rst_b_ready", axi_b_ready, 0);
    check("rst_outs", {axi_aw_addr, axi_w_data, axi_w_strb,
                       done_resp, done_cmd_err}, 0);
    axi_reset = 0;
    @(negedge axi_clk);
    check("rst_release_ready", cmd_ready, 1);

    // Aligned full-width INCR
    axi_b_id = 8'h5A;
    run_cmd(32'h100, 8'd3, 3'd2, 2'd1, 8'h5A, 32'h10);
    check("t1_aw", r_aw, {32'h100, 8'd3, 3'd2, 2'd1, 8'h5A});
    check("t1_aw_first", r_aw_first, 1);
    check("t1_w_first", r_w_first, 2);
    check_run(4, 32'h10, 64'hFFFF, 7, 2'b00, 0);

    // Unaligned narrow INCR
    axi_b_id = 8'h01;
    run_cmd(32'h103, 8'd2, 3'd1, 2'd1, 8'h01, 32'hA0);
    check_run(3, 32'hA0, 64'hC38, 6, 2'b00, 0);

    // WRAP
    axi_b_id = 8'h02;
    run_cmd(32'h38, 8'd3, 3'd2, 2'd2, 8'h02, 32'h20);
    check("t3_aw", r_aw, {32'h38, 8'd3, 3'd2, 2'd2, 8'h02});
    check_run(4, 32'h20, 64'hFFFF, 7, 2'b00, 0);

    // FIXED narrow byte lane
    axi_b_id = 8'h03;
    run_cmd(32'h101, 8'd2, 3'd0, 2'd0, 8'h03, 32'h7);
    check_run(3, 32'h7, 64'h222, 6, 2'b00, 0);

    // INCR ending exactly on the page end
    axi_b_id = 8'h04;
    run_cmd(32'hFF8, 8'd1, 3'd2, 2'd1, 8'h04, 32'h9);
    check_run(2, 32'h9, 64'hFF, 5, 2'b00, 0);

    // Stalls, error response, mismatched ID, data wrap
    aw_stall_n = 3; w_pat = 4'b1001;
    axi_b_resp = 2'b10; axi_b_id = 8'h41;
    run_cmd(32'h200, 8'd3, 3'd2, 2'd1, 8'h40, 32'hFFFF_FFFE);
    check("t6_aw", r_aw, {32'h200, 8'd3, 3'd2, 2'd1, 8'h40});
    check_run(4, 32'hFFFF_FFFE, 64'hFFFF, -1, 2'b10, 1);
    aw_stall_n = 0; w_pat = 4'hF; axi_b_resp = 2'b00;

    run_illegal(32'h100, 8'd1, 3'd2, 2'd3);
    run_illegal(32'h40, 8'd2, 3'd2, 2'd2);
    run_illegal(32'hFFC, 8'd1, 3'd2, 2'd1);
    run_illegal(32'h100, 8'd0, 3'd3, 2'd1);
    run_illegal(32'h42, 8'd3, 3'd2, 2'd2);

    // Reset during beat 1 of a len-7 burst
    rst_seen = 0;
    check("t7_cmd_ready", cmd_ready, 1);
    cmd_valid = 1; cmd_addr = 32'h300; cmd_len = 8'd7;
    cmd_size = 3'd2; cmd_burst = 2'd1; cmd_id = 8'h07;
    cmd_seed = 32'h50;
    @(negedge axi_clk);
    cmd_valid = 0;
    for (int k = 0; k < 20; k++) begin
      if (axi_w_valid && axi_w_data == 32'h51) begin
        rst_seen = 1;
        break;
      end
      @(negedge axi_clk);
    end
    check("t7_reach_beat1", rst_seen, 1);
    axi_reset = 1;
    @(negedge axi_clk);
    check("t7_valids", {axi_aw_valid, axi_w_valid, done_valid}, 0);
    check("t7_b_ready", axi_b_ready, 0);
    check("t7_ready_in_rst", cmd_ready, 0);
    axi_reset = 0;
    @(negedge axi_clk);
    check("t7_ready_after", cmd_ready, 1);
    check("t7_no_done", done_valid, 0);

    axi_b_id = 8'h08;
    run_cmd(32'h400, 8'd0, 3'd2, 2'd1, 8'h08, 32'h77);
    check_run(1, 32'h77, 64'hF, 4, 2'b00, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
